// File: rtl/wishbone_initiator_if.sv
// wishbone_interface: classic Wishbone B3/B4 signal bundle shared by the
// initiator and the register-slave peripherals.
//   master modport: drives cyc, stb, we, adr, sel, dat_mosi; samples dat_miso, ack, err
//   slave  modport: the mirror image
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, dat_mosi,
        input  dat_miso, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_mosi,
        output dat_miso, ack, err
    );
endinterface

// File: rtl/wishbone_initiator.sv
// wishbone_initiator: single-outstanding Wishbone initiator. Converts a
// valid/ready command into one classic Wishbone cycle and returns the result
// on a valid/ready response channel. A watchdog aborts cycles that receive no
// ack/err within TIMEOUT strobe cycles (TIMEOUT=0 disables it).
//   clk, rst             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; cmd_we/adr/sel/wdata payload
//   rsp_valid/rsp_ready  : response handshake; rsp_rdata/err/timeout payload
//   wishbone             : master side of the bus, all outputs registered
module wishbone_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [31:0]              cmd_adr,
    input  logic [3:0]               cmd_sel,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    wishbone_interface.master        wishbone
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_to_q, rsp_to_d;
    logic [31:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        timer_d     = timer_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // wdata goes out on reads too; slaves ignore it
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    sel_d   = cmd_sel;
                    dat_d   = cmd_wdata;
                    cyc_d   = 1'b1;
                    timer_d = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wishbone.ack || wishbone.err) begin
                    // err wins when a slave raises both
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wishbone.err;
                    rsp_to_d    = 1'b0;
                    rsp_rdata_d = (wishbone.err || we_q) ? 32'h0 : wishbone.dat_miso;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && timer_q == TO_LAST) begin
                    // timer counts completed strobe cycles, so stb stays
                    // high for exactly TIMEOUT cycles
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = RESP;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready         = (state_q == IDLE);
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_err           = rsp_err_q;
    assign rsp_timeout       = rsp_to_q;

    // stb shares the cyc flop: single-beat classic cycles only
    assign wishbone.cyc      = cyc_q;
    assign wishbone.stb      = cyc_q;
    assign wishbone.we       = we_q;
    assign wishbone.adr      = adr_q;
    assign wishbone.sel      = sel_q;
    assign wishbone.dat_mosi = dat_q;

endmodule

// File: tb/tb_wishbone_initiator.sv
module tb_wishbone_initiator;

    localparam logic [31:0] ADDRESS = 32'h1000_0000;
    localparam logic [31:0] SIZE    = 32'h0000_0100;
    localparam logic [31:0] BOTHADR = 32'h2000_0000;
    localparam int          TO      = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: TIMEOUT=8
    logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
    logic [31:0] cmd_adr = 0, cmd_wdata = 0;
    logic [3:0]  cmd_sel = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    wishbone_interface wb();

    wishbone_initiator #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .wishbone(wb)
    );

    // DUT 1: TIMEOUT=0 against a very slow slave
    logic        cmd1_valid = 0, cmd1_ready, cmd1_we = 0;
    logic [31:0] cmd1_adr = 0, cmd1_wdata = 0;
    logic [3:0]  cmd1_sel = 0;
    logic        rsp1_valid, rsp1_ready = 0, rsp1_err, rsp1_timeout;
    logic [31:0] rsp1_rdata;
    wishbone_interface wb1();

    wishbone_initiator #(.TIMEOUT(0)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready), .cmd_we(cmd1_we),
        .cmd_adr(cmd1_adr), .cmd_sel(cmd1_sel), .cmd_wdata(cmd1_wdata),
        .rsp_valid(rsp1_valid), .rsp_ready(rsp1_ready), .rsp_rdata(rsp1_rdata),
        .rsp_err(rsp1_err), .rsp_timeout(rsp1_timeout), .wishbone(wb1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address map: slave window ok, BOTHADR window raises ack+err,
    // 0x3xxx_xxxx never answers, everything else errs.
    function automatic int cls(input logic [31:0] a);
        if (a >= ADDRESS && a < ADDRESS + SIZE) return 0;
        if (a >= BOTHADR && a < BOTHADR + SIZE) return 2;
        if (a[31:28] == 4'h3) return 3;
        return 1;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // ---------------- slave for DUT 0 (registered ack, programmable wait)
    logic        slv_ack, slv_err, stray_ack = 0;
    logic [31:0] slv_rdata;
    logic [31:0] slv_mem [64];
    int          slv_wait = 0;
    int          wcnt;

    assign wb.ack      = slv_ack | stray_ack;
    assign wb.err      = slv_err;
    assign wb.dat_miso = slv_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_ack   <= 0;
            slv_err   <= 0;
            slv_rdata <= 0;
            wcnt      <= 0;
        end else begin
            slv_ack <= 0;
            slv_err <= 0;
            if (wb.cyc && wb.stb && !slv_ack && !slv_err) begin
                if (wcnt == slv_wait) begin
                    case (cls(wb.adr))
                        0: begin
                            slv_ack <= 1;
                            if (wb.we)
                                slv_mem[wb.adr[7:2]] <= (slv_mem[wb.adr[7:2]] & ~bmask(wb.sel))
                                                      | (wb.dat_mosi & bmask(wb.sel));
                            else
                                slv_rdata <= slv_mem[wb.adr[7:2]];
                        end
                        1: slv_err <= 1;
                        2: begin slv_ack <= 1; slv_err <= 1; end
                        default: ;
                    endcase
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end
    end

    // ---------------- slave for DUT 1: acks after ~1000 strobe cycles
    logic ack1;
    int   c1;
    assign wb1.ack      = ack1;
    assign wb1.err      = 1'b0;
    assign wb1.dat_miso = 32'hCAFE_0001;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack1 <= 0;
            c1   <= 0;
        end else begin
            ack1 <= 0;
            if (wb1.cyc && wb1.stb && !ack1) begin
                if (c1 == 999) ack1 <= 1;
                else c1 <= c1 + 1;
            end else begin
                c1 <= 0;
            end
        end
    end

    // ---------------- reference model: expected bus contents
    logic [31:0] ref_mem [64];

    task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wd, input int w, input int bp,
                       output logic [31:0] rd);
        int          k, c, lat, stbc, exp_lat;
        logic        exp_err, exp_to;
        logic [31:0] exp_rd;
        k       = cls(adr);
        exp_err = (k != 0);
        exp_to  = (k == 3);
        exp_rd  = (k == 0 && !we) ? ref_mem[adr[7:2]] : 32'h0;
        exp_lat = (k == 3) ? TO : w + 2;
        slv_wait = w;

        @(negedge clk);
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_wdata = wd;
        c = 0;
        while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        // later command changes must be ignored
        cmd_valid = 0; cmd_we = 1'($urandom); cmd_adr = $urandom;
        cmd_sel = 4'($urandom); cmd_wdata = $urandom;

        lat = 1; stbc = 0;
        while (lat < 2000) begin
            if (wb.stb) begin
                stbc++;
                if (stbc == 1) begin
                    chk("wb_cyc", wb.cyc, 1);
                    chk("wb_adr", wb.adr, adr);
                    chk("wb_sel", wb.sel, sel);
                    chk("wb_we", wb.we, we);
                    chk("wb_dat", wb.dat_mosi, wd);
                end
            end
            if (rsp_valid) break;
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", rsp_valid, 1);
        chk("latency", lat - 1, exp_lat);
        chk("stb_cycles", stbc, exp_lat);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("cyc_after", wb.cyc, 0);

        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1;
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, exp_rd);
            chk("bp_err", {rsp_err, rsp_timeout}, {exp_err, exp_to});
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_cyc", wb.cyc, 0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("taken_valid", rsp_valid, 0);
        chk("taken_ready", cmd_ready, 1);
        chk("taken_rdata", rsp_rdata, exp_rd);
        rd = rsp_rdata;

        if (k == 0 && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[7:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        logic [31:0] rd;
        int          r, stb1, n;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin slv_mem[i] = 0; ref_mem[i] = 0; end

        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", {wb.cyc, wb.stb, wb.we}, 0);
        chk("rst_adr_sel", {wb.adr, wb.sel}, 0);
        chk("rst_dat", wb.dat_mosi, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // directed
        txn(1, ADDRESS, 4'hF, 32'h1234_5678, 0, 0, rd);
        txn(0, ADDRESS, 4'hF, 32'h0, 0, 0, rd);
        chk("wr_rd", rd, 32'h1234_5678);
        txn(1, ADDRESS + 4, 4'hF, 32'h0, 0, 0, rd);
        txn(1, ADDRESS + 4, 4'b0100, 32'hAABB_CCDD, 1, 0, rd);
        txn(0, ADDRESS + 4, 4'hF, 32'h0, 0, 0, rd);
        chk("byte_lane", rd, 32'h00BB_0000);
        txn(0, ADDRESS + SIZE, 4'hF, 32'h5555_5555, 0, 0, rd);
        txn(1, 32'h3000_0000, 4'hF, 32'h1111_2222, 0, 0, rd);
        txn(1, BOTHADR + 16, 4'hF, 32'h3333_4444, 0, 0, rd);
        txn(1, ADDRESS + 8, 4'hF, 32'hDEAD_BEEF, 0, 0, rd);
        txn(0, ADDRESS + 8, 4'hF, 32'h0, 0, 5, rd);
        chk("bp_deadbeef", rd, 32'hDEAD_BEEF);

        // randomized
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            n = $urandom_range(0, 63);
            if (r <= 6)      a = ADDRESS + {n[29:0], 2'b00};
            else if (r == 7) a = 32'h5000_0000 + {n[29:0], 2'b00};
            else if (r == 8) a = BOTHADR + {n[29:0], 2'b00};
            else             a = 32'h3000_0000 + {n[29:0], 2'b00};
            txn(1'($urandom), a, 4'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), rd);
        end

        // async reset while strobing a silent address
        @(negedge clk);
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        chk("pre_rst_stb", wb.stb, 1);
        #1 rst = 0;
        #1;
        chk("async_cyc_stb", {wb.cyc, wb.stb}, 0);
        chk("async_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_ready", cmd_ready, 1);
        stray_ack = 1;
        @(negedge clk);
        stray_ack = 0;
        @(negedge clk);
        chk("stray_ack_valid", rsp_valid, 0);
        chk("stray_ack_cyc", wb.cyc, 0);
        chk("stray_ack_ready", cmd_ready, 1);
        txn(0, ADDRESS, 4'hF, 32'h0, 0, 0, rd);
        chk("after_rst_rd", rd, 32'h1234_5678);

        // TIMEOUT=0: slow slave still completes normally
        @(negedge clk);
        cmd1_valid = 1; cmd1_we = 0; cmd1_adr = 32'h0000_0100; cmd1_sel = 4'hF;
        @(negedge clk);
        cmd1_valid = 0;
        stb1 = 0; n = 0;
        while (!rsp1_valid && n < 1500) begin
            if (wb1.stb) stb1++;
            @(negedge clk);
            n++;
        end
        chk("to0_done", rsp1_valid, 1);
        chk("to0_long", stb1 >= 1000, 1);
        chk("to0_err", {rsp1_err, rsp1_timeout}, 0);
        chk("to0_rdata", rsp1_rdata, 32'hCAFE_0001);
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
        chk("to0_taken", {rsp1_valid, cmd1_ready}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_initiator.md
Name: wishbone_initiator

Overview:
Single-outstanding Wishbone initiator that turns a simple command/response handshake into classic Wishbone cycles on a `wishbone_interface.master` port. It is the initiator-side counterpart of our register-slave peripherals (segments, GPIO, timer) and lets non-CPU logic read and write them. Typical users are a debug bridge, a DMA sequencer, or a boot loader. It also includes a bus-timeout watchdog, so an unmapped or hung slave cannot stall the requester.

Parameters:
TIMEOUT, 255, number of cycles with stb high and no ack/err before the cycle is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  32  byte address, forwarded unchanged to wishbone.adr
cmd_sel  in  4  byte lane enables
cmd_wdata  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes response
rsp_rdata  out  32  read data (0 for writes and errors)
rsp_err  out  1  slave returned err, or timeout
rsp_timeout  out  1  error was caused by timeout
wishbone  master  -  `wishbone_interface.master`: cyc, stb, we, adr, sel, dat_mosi out; dat_miso, ack, err in

Behaviour:
- Reset (rst=0, async): state IDLE; cyc=stb=we=0; adr=sel=dat_mosi=0; rsp_valid=rsp_err=rsp_timeout=0; rsp_rdata=0; timer=0. cmd_ready=1 once rst releases.
- All Wishbone outputs are registered. The requester's handshakes complete on the rising edge where valid && ready.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd accept: latch we/adr/sel/wdata onto the wishbone outputs. cyc=stb=1 from the next cycle. timer cleared. Go to BUS.
  - dat_mosi is driven with cmd_wdata on reads too; the slave ignores it.
- BUS:
  - cmd_ready=0. cyc/stb/adr/sel/we/dat_mosi held stable.
  - Edge where ack=1 or err=1 is sampled: cyc=stb=0 at that edge; rsp_valid=1; go to RESP.
    - ack and err both 1: treated as err.
    - err: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
    - ack on a read: rsp_rdata=dat_miso, rsp_err=0.
    - ack on a write: rsp_rdata=0, rsp_err=0.
  - Otherwise timer increments. If TIMEOUT!=0 and timer==TIMEOUT-1 at an edge with no ack/err: cyc=stb=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP. So stb is high for exactly TIMEOUT cycles.
  - timer is 32 bits. With TIMEOUT=0 it saturates at all-ones and never aborts.
- RESP:
  - cmd_ready=0. rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE. rsp_rdata/rsp_err/rsp_timeout keep their values until the next response.
  - The next command can be accepted one cycle after the response is taken; there is no command/response overlap.
- Latency against a registered single-cycle-ack slave:
  - accept at edge E; stb high in cycle E+1; slave ack sampled at edge E+2; rsp_valid=1 from E+2.
  - The deassertion of cyc at E+2 coincides with the slave's ack==1 self-block, so no double ack occurs.
- ack/err seen while not in BUS is ignored.
- cmd_* inputs change only matter at the accept edge; later changes are ignored.
- Reset mid-cycle (BUS or RESP): cyc/stb drop immediately (asynchronously), the pending response is discarded, return to IDLE.

Test Plan:
- Write-then-read: write adr=ADDRESS, sel=4'hF, wdata=32'h1234_5678 → single stb pulse, rsp_err=0; then read the same adr → rsp_rdata=32'h1234_5678, rsp_valid 2 cycles after accept.
- Byte lanes: write sel=4'b0100, wdata=32'hAABB_CCDD over 32'h0 → subsequent read returns 32'h00BB_0000.
- Slave err: address outside slave range (ADDRESS+SIZE) → rsp_err=1, rsp_timeout=0, rsp_rdata=0, cyc low the cycle after err.
- Timeout: TIMEOUT=8, no slave responds → stb high exactly 8 cycles, then rsp_err=1, rsp_timeout=1. With TIMEOUT=0 and a slave acking after 1000 cycles → normal completion.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of 32'hDEAD_BEEF → rsp_valid and data stable, cmd_ready=0, no new cyc while cmd_valid=1. After release, the next command is accepted one cycle later.
- Async reset: drop rst while in BUS (stb high) → cyc/stb=0 without waiting for a clock edge. After release, rsp_valid=0, cmd_ready=1, and a late ack is ignored.
